// File: rtl/pwm_symbol_encoder.sv
// rtl/pwm_symbol_encoder.sv - PWM frame encoder for signed 8-bit symbols; guard phase enabled by PWM_ENC_GUARD_EN
module pwm_symbol_encoder #(
  parameter int AMPLITUDE      = 256,
  parameter int TICKS_PER_STEP = 4,
  parameter int GUARD_TICKS    = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic signed [7:0]  symbol_in,
  input  logic               symbol_valid,
  output logic               symbol_ready,
  output logic signed [15:0] data_out,
  output logic               frame_start,
  output logic               busy
);

  localparam logic signed [15:0] AMP_POS = 16'(AMPLITUDE);
  localparam logic signed [15:0] AMP_NEG = -AMP_POS;
  localparam logic [15:0]        STEP    = 16'(TICKS_PER_STEP);

  // Reject parameter values whose phase lengths would not fit the 16-bit counter.
  if (AMPLITUDE < 1 || AMPLITUDE > 32767) begin : g_amp_range
    $error("AMPLITUDE must be 1..32767");
  end
  if (TICKS_PER_STEP < 1 || TICKS_PER_STEP > 255) begin : g_step_range
    $error("TICKS_PER_STEP must be 1..255");
  end
  if (GUARD_TICKS < 1 || GUARD_TICKS > 65535) begin : g_guard_range
    $error("GUARD_TICKS must be 1..65535");
  end

`ifdef PWM_ENC_GUARD_EN
  typedef enum logic [1:0] {IDLE, GUARD, HIGH, LOW} state_t;
`else
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
`endif

  state_t             state_q;
  logic [15:0]        cnt_q;
  logic [8:0]         u_q;
  logic signed [15:0] data_q;
  logic               frame_start_q;
  logic               busy_q;

  logic [8:0]         u_in;
  logic               accept;
  state_t             start_state;
  logic [15:0]        start_cnt;
  logic signed [15:0] start_data;

  // Last count value of the HIGH phase for offset code u: (u+1)*step - 1.
  function automatic logic [15:0] high_last(input logic [8:0] u);
    return (({7'd0, u} + 16'd1) * STEP) - 16'd1;
  endfunction

  // Last count value of the LOW phase for offset code u: (256-u)*step - 1.
  function automatic logic [15:0] low_last(input logic [8:0] u);
    return ((16'd256 - {7'd0, u}) * STEP) - 16'd1;
  endfunction

  // symbol + 128 is the two's-complement value with its sign bit flipped.
  assign u_in = {1'b0, ~symbol_in[7], symbol_in[6:0]};

  // A new symbol is taken when idle, or on the very last enabled LOW tick so frames abut.
  assign symbol_ready = (state_q == IDLE) | ((state_q == LOW) & (cnt_q == 16'd0) & enable);
  assign accept       = symbol_valid & symbol_ready;

  // First phase of a frame: guard zeros when present, otherwise straight into the pulse.
  always_comb begin
`ifdef PWM_ENC_GUARD_EN
    start_state = GUARD;
    start_cnt   = 16'(GUARD_TICKS - 1);
    start_data  = '0;
`else
    start_state = HIGH;
    start_cnt   = high_last(u_in);
    start_data  = AMP_POS;
`endif
  end

  // Frame FSM: phase sequencing, tick counting and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      u_q           <= '0;
      data_q        <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (accept) begin
        state_q       <= start_state;
        cnt_q         <= start_cnt;
        data_q        <= start_data;
        u_q           <= u_in;
        frame_start_q <= 1'b1;
        busy_q        <= 1'b1;
      end else if ((state_q != IDLE) && enable) begin
        if (cnt_q != 16'd0) begin
          cnt_q <= cnt_q - 16'd1;
        end else begin
          case (state_q)
`ifdef PWM_ENC_GUARD_EN
            GUARD: begin
              state_q <= HIGH;
              data_q  <= AMP_POS;
              cnt_q   <= high_last(u_q);
            end
`endif
            HIGH: begin
              state_q <= LOW;
              data_q  <= AMP_NEG;
              cnt_q   <= low_last(u_q);
            end
            default: begin
              state_q <= IDLE;
              data_q  <= '0;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign data_out    = data_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pwm_symbol_encoder.sv
// tb/tb_pwm_symbol_encoder.sv - table-driven and sequence checks for pwm_symbol_encoder
`timescale 1ns/1ps
module tb_pwm_symbol_encoder;

`ifdef PWM_ENC_GUARD_EN
  localparam int G = 16;
`else
  localparam int G = 0;
`endif
  localparam int AMP = 256;
  localparam int FL  = G + 1028;

  logic               clock;
  logic               reset_n;
  logic               enable;
  logic signed [7:0]  symbol_in;
  logic               symbol_valid;
  logic               symbol_ready;
  logic signed [15:0] data_out;
  logic               frame_start;
  logic               busy;

  pwm_symbol_encoder #(
    .AMPLITUDE(256),
    .TICKS_PER_STEP(4),
    .GUARD_TICKS(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .symbol_in(symbol_in),
    .symbol_valid(symbol_valid),
    .symbol_ready(symbol_ready),
    .data_out(data_out),
    .frame_start(frame_start),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] sym;
    bit         tog;
    int         hi;
    int         lo;
  } vec_t;

  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;

  int nz, np, nn, order_err, clocks, extra_fs, ready_bad, first;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Send one symbol from idle and tally the samples seen on enabled cycles.
  task automatic run_frame(input logic [7:0] sym, input bit tog);
    int k;
    int phase;
    nz = 0; np = 0; nn = 0; order_err = 0; clocks = 0;
    extra_fs = 0; ready_bad = 0; first = 0;
    symbol_in = sym;
    symbol_valid = 1'b1;
    enable = 1'b1;
    @(posedge clock); #1;
    symbol_valid = 1'b0;
    check("accept_frame_start", frame_start, 1);
    check("accept_busy", busy, 1);
    phase = 0;
    k = 0;
    while (busy && k < 5000) begin
      enable = tog ? k[0] : 1'b1;
      #1;
      if (k == 0) first = data_out;
      if (k > 0 && frame_start) extra_fs++;
      if (!enable && symbol_ready) ready_bad++;
      if (enable) begin
        if (data_out == 0) begin
          if (phase != 0) order_err++;
          nz++;
        end else if (data_out == AMP) begin
          if (phase > 1) order_err++;
          phase = 1;
          np++;
        end else if (data_out == -AMP) begin
          if (phase == 0) order_err++;
          phase = 2;
          nn++;
        end else begin
          order_err++;
        end
      end
      clocks++;
      k++;
      @(posedge clock); #1;
    end
    enable = 1'b1;
    #1;
    check("frame_timeout", int'(k < 5000), 1);
  endtask

  int c, fs2, gap, p1, n1, p2, n2, prev, tr_prev, tr_now;
  bit done;

  initial begin
    vecs[0] = '{8'h80, 1'b0,    4, 1024};
    vecs[1] = '{8'h7F, 1'b0, 1024,    4};
    vecs[2] = '{8'h00, 1'b0,  516,  512};
    vecs[3] = '{8'hFF, 1'b0,  512,  516};
    vecs[4] = '{8'h05, 1'b0,  536,  492};
    vecs[5] = '{8'h9C, 1'b0,  116,  912};
    vecs[6] = '{8'h00, 1'b1,  516,  512};

    reset_n = 1'b0;
    enable = 1'b1;
    symbol_in = '0;
    symbol_valid = 1'b0;
    #2;
    check("reset_data", data_out, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_ready", symbol_ready, 1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Table of single frames from idle.
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].sym, vecs[i].tog);
      check($sformatf("v%0d_first", i), first, (G > 0) ? 0 : AMP);
      check($sformatf("v%0d_guard", i), nz, G);
      check($sformatf("v%0d_high", i), np, vecs[i].hi);
      check($sformatf("v%0d_low", i), nn, vecs[i].lo);
      check($sformatf("v%0d_order", i), order_err, 0);
      check($sformatf("v%0d_clocks", i), clocks, vecs[i].tog ? 2 * FL : FL);
      check($sformatf("v%0d_extra_fs", i), extra_fs, 0);
      check($sformatf("v%0d_ready_dis", i), ready_bad, 0);
      check($sformatf("v%0d_end_data", i), data_out, 0);
      check($sformatf("v%0d_end_ready", i), symbol_ready, 1);
    end

    // Back-to-back: symbol 0 then -1 with valid held.
    symbol_in = 8'h00;
    symbol_valid = 1'b1;
    enable = 1'b1;
    @(posedge clock); #1;
    symbol_in = 8'hFF;
    fs2 = -1; c = 0; gap = 0; p1 = 0; n1 = 0; p2 = 0; n2 = 0;
    prev = 0; tr_prev = 0; tr_now = 0; done = 1'b0;
    while (!done && c < 5000) begin
      if (!busy) begin
        done = 1'b1;
        if (fs2 < 0) gap++;
      end else begin
        if (c > 0 && frame_start && fs2 < 0) begin
          fs2 = c;
          symbol_valid = 1'b0;
          tr_prev = prev;
          tr_now = data_out;
        end
        if (fs2 < 0) begin
          if (data_out == AMP) p1++;
          else if (data_out == -AMP) n1++;
        end else begin
          if (data_out == AMP) p2++;
          else if (data_out == -AMP) n2++;
        end
        prev = data_out;
        c++;
        @(posedge clock); #1;
      end
    end
    symbol_valid = 1'b0;
    check("b2b_done", int'(done), 1);
    check("b2b_gap", gap, 0);
    check("b2b_spacing", fs2, FL);
    check("b2b_f1_high", p1, 516);
    check("b2b_f1_low", n1, 512);
    check("b2b_f2_high", p2, 512);
    check("b2b_f2_low", n2, 516);
    check("b2b_last_low", tr_prev, -AMP);
    check("b2b_next_first", tr_now, (G > 0) ? 0 : AMP);
    check("b2b_total", c, 2 * FL);

    // Asynchronous reset in the middle of the HIGH phase.
    symbol_in = 8'h00;
    symbol_valid = 1'b1;
    @(posedge clock); #1;
    symbol_valid = 1'b0;
    repeat (100) @(posedge clock);
    #3;
    check("pre_reset_high", data_out, AMP);
    reset_n = 1'b0;
    #1;
    check("async_rst_data", data_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", symbol_ready, 1);
    check("async_rst_fs", frame_start, 0);
    @(negedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_frame(8'h05, 1'b0);
    check("post_rst_guard", nz, G);
    check("post_rst_high", np, 536);
    check("post_rst_low", nn, 492);
    check("post_rst_order", order_err, 0);
    check("post_rst_clocks", clocks, FL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
